// File: rtl/nlprg_period_mon.sv
// Measures the cycle length of a PRNG stream: records the first sample as seed,
// tracks visited words in a bitmap and reports the period, full-period pass and error cause.
module nlprg_period_mon #(
  parameter int unsigned N         = 5,
  parameter int unsigned STALL_MAX = 64
) (
  input  logic         ck,
  input  logic         rst_n,
  input  logic         start,
  input  logic         in_vld,
  input  logic [N-1:0] in_dat,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   period,
  output logic [1:0]   err
);

  localparam int unsigned DEPTH = 1 << N;
  localparam int unsigned CW    = N + 1;
  localparam int unsigned SW    = $clog2(STALL_MAX + 1);

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_SHORT  = 2'b01;
  localparam logic [1:0] ERR_REPEAT = 2'b10;
  localparam logic [1:0] ERR_STALL  = 2'b11;

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [DEPTH-1:0]   bitmap, bitmap_nxt;
  logic [N-1:0]       seed, seed_nxt;
  logic [CW-1:0]      count, count_nxt;
  logic [SW-1:0]      stall, stall_nxt;
  logic               pass_nxt, busy_nxt, done_nxt;
  logic [CW-1:0]      period_nxt;
  logic [1:0]         err_nxt;

  logic stall_end_c, seed_hit_c, seen_c, full_c;

  assign stall_end_c = !in_vld && (stall == SW'(STALL_MAX - 1));
  assign seed_hit_c  = (in_dat == seed);
  assign seen_c      = bitmap[in_dat];
  assign full_c      = (count == CW'(DEPTH));

  // State register
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = ARM;
      ARM: begin
        if (in_vld)           state_nxt = RUN;
        else if (stall_end_c) state_nxt = DONE;
      end
      RUN: begin
        if (in_vld) begin
          if (seed_hit_c || seen_c) state_nxt = DONE;
        end else if (stall_end_c) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and result next values
  always_comb begin
    bitmap_nxt = bitmap;
    seed_nxt   = seed;
    count_nxt  = count;
    stall_nxt  = stall;
    pass_nxt   = pass;
    period_nxt = period;
    err_nxt    = err;
    busy_nxt   = (state_nxt == ARM) || (state_nxt == RUN);
    done_nxt   = (state_nxt == DONE);
    case (state)
      IDLE, DONE: begin
        if (start) begin
          bitmap_nxt = '0;
          count_nxt  = '0;
          stall_nxt  = '0;
          pass_nxt   = 1'b0;
          err_nxt    = ERR_NONE;
          period_nxt = '0;
        end
      end
      ARM, RUN: begin
        if (!in_vld) begin
          if (stall != SW'(STALL_MAX)) stall_nxt = stall + SW'(1);
          if (stall_end_c) begin
            pass_nxt   = 1'b0;
            err_nxt    = ERR_STALL;
            period_nxt = count;
          end
        end else if (state == ARM) begin
          seed_nxt           = in_dat;
          bitmap_nxt[in_dat] = 1'b1;
          count_nxt          = CW'(1);
          stall_nxt          = '0;
        end else if (seed_hit_c) begin
          period_nxt = count;
          pass_nxt   = full_c;
          err_nxt    = full_c ? ERR_NONE : ERR_SHORT;
        end else if (seen_c) begin
          period_nxt = count;
          pass_nxt   = 1'b0;
          err_nxt    = ERR_REPEAT;
        end else begin
          bitmap_nxt[in_dat] = 1'b1;
          if (!full_c) count_nxt = count + CW'(1);
          stall_nxt = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      bitmap <= '0;
      seed   <= '0;
      count  <= '0;
      stall  <= '0;
      pass   <= 1'b0;
      period <= '0;
      err    <= ERR_NONE;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      bitmap <= bitmap_nxt;
      seed   <= seed_nxt;
      count  <= count_nxt;
      stall  <= stall_nxt;
      pass   <= pass_nxt;
      period <= period_nxt;
      err    <= err_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_nlprg_period_mon.sv
// Scoreboard bench for nlprg_period_mon: a sequence-level reference model predicts
// each measurement result; a monitor pops and compares on every rising done.
module tb_nlprg_period_mon;

  localparam int N         = 5;
  localparam int STALL_MAX = 64;
  localparam int DEPTH     = 32;

  typedef struct {
    bit         vld;
    bit [N-1:0] dat;
  } smp_t;

  typedef struct {
    bit         pass;
    bit [N:0]   period;
    bit [1:0]   err;
  } res_t;

  logic         ck = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         in_vld = 1'b0;
  logic [N-1:0] in_dat = '0;
  logic         busy, done, pass;
  logic [N:0]   period;
  logic [1:0]   err;

  int   n_chk  = 0;
  int   n_fail = 0;
  res_t sb_q[$];
  logic done_d = 1'b0;

  nlprg_period_mon #(.N(N), .STALL_MAX(STALL_MAX)) dut (
    .ck(ck), .rst_n(rst_n), .start(start), .in_vld(in_vld), .in_dat(in_dat),
    .busy(busy), .done(done), .pass(pass), .period(period), .err(err)
  );

  always #5 ck = ~ck;

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  // Reference: walk the per-cycle sample list after start and apply the measurement rules.
  function automatic void model(input smp_t s[$], output res_t r, output int term);
    bit seen[int];
    int cnt = 0;
    int stl = 0;
    int sd  = -1;
    r    = '{1'b0, 6'd0, 2'd0};
    term = s.size() - 1;
    for (int i = 0; i < s.size(); i++) begin
      if (!s[i].vld) begin
        stl++;
        if (stl == STALL_MAX) begin
          r = '{1'b0, 6'(cnt), 2'd3}; term = i; return;
        end
      end else begin
        stl = 0;
        if (sd < 0) begin
          sd = int'(s[i].dat); seen[sd] = 1'b1; cnt = 1;
        end else if (int'(s[i].dat) == sd) begin
          r = '{(cnt == DEPTH), 6'(cnt), (cnt == DEPTH) ? 2'd0 : 2'd1}; term = i; return;
        end else if (seen.exists(int'(s[i].dat))) begin
          r = '{1'b0, 6'(cnt), 2'd2}; term = i; return;
        end else begin
          seen[int'(s[i].dat)] = 1'b1; cnt++;
        end
      end
    end
  endfunction

  // Monitor: every new done pops one expected result
  always @(negedge ck) begin
    res_t e;
    if (done && !done_d) begin
      if (sb_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb_q.pop_front();
        chk("sb_pass", int'(pass), int'(e.pass));
        chk("sb_period", int'(period), int'(e.period));
        chk("sb_err", int'(err), int'(e.err));
      end
    end
    done_d = done;
  end

  task automatic run_meas(input string nm, input smp_t s[$], input bit mid_start);
    res_t e;
    int   term;
    model(s, e, term);
    sb_q.push_back(e);
    @(negedge ck);
    start = 1'b1; in_vld = 1'($urandom); in_dat = N'($urandom);
    @(negedge ck);
    start = 1'b0;
    chk({nm, "_busy_arm"}, int'(busy), 1);
    chk({nm, "_clr_period"}, int'(period), 0);
    chk({nm, "_clr_err"}, int'(err), 0);
    for (int i = 0; i <= term; i++) begin
      in_vld = s[i].vld;
      in_dat = s[i].dat;
      start  = mid_start && (i > 0) && ($urandom_range(0, 7) == 0);
      @(negedge ck);
    end
    start = 1'b0;
    chk({nm, "_done_latency"}, int'(done), 1);
    chk({nm, "_busy_done"}, int'(busy), 0);
    repeat (3) begin
      in_vld = 1'($urandom); in_dat = N'($urandom);
      @(negedge ck);
    end
    chk({nm, "_hold_done"}, int'(done), 1);
    chk({nm, "_hold_pass"}, int'(pass), int'(e.pass));
    chk({nm, "_hold_period"}, int'(period), int'(e.period));
    chk({nm, "_hold_err"}, int'(err), int'(e.err));
    for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(negedge ck);
    chk({nm, "_sb_drain"}, sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic add_idle(inout smp_t q[$], input int n);
    for (int i = 0; i < n; i++) q.push_back('{1'b0, N'($urandom)});
  endtask

  task automatic add_val(inout smp_t q[$], input int d, input bit gaps);
    if (gaps && ($urandom_range(0, 3) == 0)) add_idle(q, $urandom_range(1, 5));
    q.push_back('{1'b1, N'(d)});
  endtask

  initial begin
    smp_t q[$];
    int   p[DEPTH];
    int   t, j, x;

    repeat (3) @(negedge ck);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst_n = 1'b1;
    repeat (3) begin
      in_vld = 1'($urandom); in_dat = N'($urandom);
      @(negedge ck);
    end
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);
    chk("idle_pass", int'(pass), 0);
    chk("idle_period", int'(period), 0);
    chk("idle_err", int'(err), 0);

    q.delete(); for (int i = 0; i < DEPTH; i++) add_val(q, i, 1'b0);
    add_val(q, 0, 1'b0); add_idle(q, 70);
    run_meas("full", q, 1'b0);

    q.delete(); for (int i = 0; i < 10; i++) add_val(q, i, 1'b0);
    add_val(q, 0, 1'b0); add_idle(q, 70);
    run_meas("short10", q, 1'b0);

    q.delete(); add_val(q, 3, 1'b0); add_val(q, 4, 1'b0); add_val(q, 5, 1'b0);
    add_val(q, 4, 1'b0); add_idle(q, 70);
    run_meas("repeat", q, 1'b0);

    q.delete(); add_idle(q, 80);
    run_meas("stall_arm", q, 1'b0);

    q.delete(); add_val(q, 17, 1'b0); add_val(q, 17, 1'b0); add_idle(q, 70);
    run_meas("lockup", q, 1'b0);

    q.delete(); add_val(q, 7, 1'b0); add_val(q, 8, 1'b0); add_idle(q, 70);
    run_meas("stall_run", q, 1'b0);

    q.delete(); add_val(q, 9, 1'b0); add_idle(q, 63); add_val(q, 10, 1'b0);
    add_val(q, 9, 1'b0); add_idle(q, 70);
    run_meas("stall_edge", q, 1'b0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) p[i] = i;
      for (int i = DEPTH - 1; i > 0; i--) begin
        j = $urandom_range(0, i); t = p[i]; p[i] = p[j]; p[j] = t;
      end
      q.delete();
      for (int i = 0; i < DEPTH; i++) add_val(q, p[i], 1'b1);
      add_val(q, p[0], 1'b1); add_idle(q, 70);
      run_meas("perm", q, 1'b1);
    end

    for (int r = 0; r < 8; r++) begin
      q.delete();
      for (int i = 0; i < 40; i++) add_val(q, int'($urandom_range(0, DEPTH - 1)), 1'b1);
      add_idle(q, 70);
      run_meas("rand", q, 1'b1);
    end

    // Abandon a measurement with reset mid-run
    @(negedge ck);
    start = 1'b1;
    @(negedge ck);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_vld = 1'b1; in_dat = N'(i + 11);
      @(negedge ck);
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_pass", int'(pass), 0);
    chk("midrst_period", int'(period), 0);
    chk("midrst_err", int'(err), 0);
    @(negedge ck);
    rst_n = 1'b1;
    repeat (4) begin
      in_vld = 1'($urandom); in_dat = N'($urandom);
      @(negedge ck);
    end
    chk("postrst_busy", int'(busy), 0);
    chk("postrst_done", int'(done), 0);

    // Free-running full-period generator: x -> 5x+3 mod 32
    x = int'($urandom_range(0, DEPTH - 1));
    q.delete();
    for (int i = 0; i < DEPTH + 8; i++) begin
      add_val(q, x, 1'b0);
      x = (5 * x + 3) % DEPTH;
    end
    add_idle(q, 70);
    run_meas("live", q, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
